game_round_driver: RTL



---
 rtl/game_pkg.sv | 21 ++
 rtl/game_lfsr16.sv | 39 +++
 rtl/game_round_driver.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game round driver and its helpers.
// Holds the driver state encoding and the constants of the 16-bit
// Fibonacci LFSR used for randomised gap lengths.
package game_pkg;

  // Driver state encoding.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WINDOW = 3'd1,
    FIRE   = 3'd2,
    CHECK  = 3'd3,
    GAP    = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int unsigned LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/game_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded on reset.
// Ports:
//   clock  - system clock
//   reset  - asynchronous, active-high; loads LFSR_SEED
//   enable - advance one step this cycle
//   q      - current LFSR state
module game_lfsr16
  import game_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;
  logic              fb_c;

  // Next state: shift left, feed back the XOR of the tapped bits.
  always_comb begin
    fb_c = ^(q_q & LFSR_TAPS);
    q_d  = q_q;
    if (enable) begin
      q_d = {q_q[LFSR_W-2:0], fb_c};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_q <= LFSR_SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/game_round_driver.sv
// Stimulus and scoring driver for the cut/rush/result game FSM.
// Each round opens a reaction window on player_key, fires w with n set to
// the hit decision, scores what the game FSM reports, then idles for a gap.
//
// Ports:
//   clock, reset          - clock; asynchronous active-high reset
//   start                 - pulse that begins a game (accepted only with cut=1)
//   player_key            - debounced key
//   cut, rush, result     - game FSM state flags
//   w, n                  - game FSM inputs (registered, Moore)
//   busy, done, error     - status; error is sticky until the next start
//   hit_count, miss_count - round scores
//   round_idx             - rounds completed
//
// Build option: define GAME_ROUND_DRIVER_RANDOM_GAP_EN to lengthen each gap
// by the low byte of a free-running LFSR (GAP_CYCLES + lfsr[7:0]).
module game_round_driver
  import game_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES    = 25_000_000,
  parameter int unsigned ROUNDS        = 10,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned TMR_W         = 32,
  parameter int unsigned FIRE_TIMEOUT  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             player_key,
  input  logic             cut,
  input  logic             rush,
  input  logic             result,
  output logic             w,
  output logic             n,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] round_idx
);

  localparam logic [TMR_W-1:0] WIN_LAST  = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] FIRE_LAST = TMR_W'(FIRE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ROUNDS_C  = CNT_W'(ROUNDS);

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              hit_q, hit_d;
  logic              w_q, w_d;
  logic              n_q, n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [CNT_W-1:0]  hit_count_q, hit_count_d;
  logic [CNT_W-1:0]  miss_count_q, miss_count_d;
  logic [CNT_W-1:0]  round_idx_q, round_idx_d;
  logic [TMR_W-1:0]  gap_last_c;

`ifdef GAME_ROUND_DRIVER_RANDOM_GAP_EN
  logic [LFSR_W-1:0] lfsr_q;
  logic [TMR_W-1:0]  gap_len_q, gap_len_d;
  logic              unused_lfsr_hi;

  game_lfsr16 u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .enable (1'b1),
    .q      (lfsr_q)
  );

  assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:8];

  // Gap length is captured in CHECK, i.e. on the edge that enters GAP.
  always_comb begin
    gap_len_d = gap_len_q;
    if (state_q == CHECK) begin
      gap_len_d = TMR_W'(GAP_CYCLES) + TMR_W'(lfsr_q[7:0]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gap_len_q <= '0;
    end else begin
      gap_len_q <= gap_len_d;
    end
  end

  assign gap_last_c = gap_len_q - TMR_W'(1);
`else
  assign gap_last_c = TMR_W'(GAP_CYCLES - 1);
`endif

  // Next-state, counter and output logic.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    hit_d        = hit_q;
    error_d      = error_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    round_idx_d  = round_idx_q;

    case (state_q)
      IDLE, DONE: begin
        // A start is only honoured while the game FSM sits in its idle state.
        if (start && cut) begin
          state_d      = WINDOW;
          timer_d      = '0;
          hit_d        = 1'b0;
          error_d      = 1'b0;
          hit_count_d  = '0;
          miss_count_d = '0;
          round_idx_d  = '0;
        end
      end

      WINDOW: begin
        if (player_key) begin
          hit_d = 1'b1;
        end
        if (timer_q == WIN_LAST) begin
          state_d = FIRE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      FIRE: begin
        if (rush) begin
          state_d = CHECK;
          timer_d = '0;
        end else if (timer_q == FIRE_LAST) begin
          state_d = IDLE;
          timer_d = '0;
          error_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      CHECK: begin
        // Exactly one of result/cut is a valid report; anything else is a miss.
        if (result && !cut) begin
          hit_count_d = hit_count_q + CNT_W'(1);
        end else begin
          miss_count_d = miss_count_q + CNT_W'(1);
          if (result == cut) begin
            error_d = 1'b1;
          end
        end
        round_idx_d = round_idx_q + CNT_W'(1);
        hit_d       = 1'b0;
        state_d     = GAP;
        timer_d     = '0;
      end

      GAP: begin
        if (timer_q == gap_last_c) begin
          timer_d = '0;
          state_d = (round_idx_q == ROUNDS_C) ? DONE : WINDOW;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    // Outputs are registered from the next state so they track the state.
    w_d    = (state_d == FIRE);
    n_d    = (state_d == FIRE) && hit_d;
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      hit_q        <= 1'b0;
      w_q          <= 1'b0;
      n_q          <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      round_idx_q  <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      hit_q        <= hit_d;
      w_q          <= w_d;
      n_q          <= n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      round_idx_q  <= round_idx_d;
    end
  end

  assign w          = w_q;
  assign n          = n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign round_idx  = round_idx_q;

endmodule
